// File: rtl/s2p_pkg.sv
// Shared definitions for the serial-to-parallel receive path: FSM encoding,
// default geometry and the channel-index width helper.
package s2p_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } s2p_state_e;

  localparam int unsigned DEF_WIDTH   = 12;
  localparam int unsigned DEF_NCH     = 4;
  localparam int unsigned DEF_TIMEOUT = 64;

  // A single-channel link still needs a 1-bit index port.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with a third stage that
// provides a one-cycle rising-edge strobe aligned to the synchronized level.
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [2:0] sync_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], d_i};
  end

  assign q_o    = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/serial2parallel.sv
// Deserializer for the AD7864 sample link: oversamples sclk/fs/sd on clkin
// and rebuilds NCH-word frames into parallel words tagged with a channel index.
module serial2parallel
  import s2p_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NCH     = DEF_NCH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clkin,
  input  logic                      rst,
  input  logic                      sclk_in,
  input  logic                      fs_in,
  input  logic                      sd_in,
  output logic [WIDTH-1:0]          data_out,
  output logic [ch_width(NCH)-1:0]  ch_out,
  output logic                      valid,
  output logic                      busy,
  output logic                      frame_err
);

  localparam int unsigned CW = ch_width(NCH);
  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(NCH - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  logic sclk_rise, fs_s, sd_s;
  logic fs_rise_unused, sd_rise_unused;

  sync_edge u_sync_sclk (.clk_i(clkin), .rst_i(rst), .d_i(sclk_in), .q_o(),     .rise_o(sclk_rise));
  sync_edge u_sync_fs   (.clk_i(clkin), .rst_i(rst), .d_i(fs_in),   .q_o(fs_s), .rise_o(fs_rise_unused));
  sync_edge u_sync_sd   (.clk_i(clkin), .rst_i(rst), .d_i(sd_in),   .q_o(sd_s), .rise_o(sd_rise_unused));

  s2p_state_e       state_q;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [CW-1:0]    word_cnt_q;
  logic [TW-1:0]    tmo_q;
  logic             full_q;
  logic             fs_prev_q;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    ch_q;
  logic             valid_q;
  logic             err_q;

  // A frame sync that is merely held high from the previous sample is not a
  // new frame; only a 0->1 transition in the sampled fs restarts mid-frame.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      tmo_q      <= '0;
      full_q     <= 1'b0;
      fs_prev_q  <= 1'b0;
      data_q     <= '0;
      ch_q       <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      if (sclk_rise) fs_prev_q <= fs_s;

      unique case (state_q)
        S_IDLE: begin
          tmo_q <= '0;
          if (sclk_rise && fs_s) begin
            state_q    <= S_SHIFT;
            shift_q    <= {{(WIDTH-1){1'b0}}, sd_s};
            bit_cnt_q  <= BW'(1);
            word_cnt_q <= '0;
          end
        end

        S_SHIFT: begin
          if (full_q) begin
            data_q    <= shift_q;
            ch_q      <= word_cnt_q;
            valid_q   <= 1'b1;
            bit_cnt_q <= '0;
            if (word_cnt_q == LAST_WORD) state_q    <= S_DONE;
            else                         word_cnt_q <= word_cnt_q + 1'b1;
          end else if (sclk_rise) begin
            tmo_q <= '0;
            if (fs_s && !fs_prev_q) begin
              err_q      <= 1'b1;
              shift_q    <= {{(WIDTH-1){1'b0}}, sd_s};
              bit_cnt_q  <= BW'(1);
              word_cnt_q <= '0;
            end else begin
              shift_q   <= {shift_q[WIDTH-2:0], sd_s};
              bit_cnt_q <= bit_cnt_q + 1'b1;
              full_q    <= (bit_cnt_q == LAST_BIT);
            end
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out  = data_q;
  assign ch_out    = ch_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial2parallel.sv
// Directed-plus-random bench for serial2parallel: drives a serial link model
// and compares recovered words against the frame contents it sent.
module tb_serial2parallel;

  localparam int W = 12;
  localparam int N = 4;

  logic clkin = 1'b0;
  logic rst, sclk_in, fs_in, sd_in;
  logic [W-1:0] data_out;
  logic [1:0]   ch_out;
  logic valid, busy, frame_err;

  serial2parallel dut (
    .clkin(clkin), .rst(rst), .sclk_in(sclk_in), .fs_in(fs_in), .sd_in(sd_in),
    .data_out(data_out), .ch_out(ch_out), .valid(valid), .busy(busy),
    .frame_err(frame_err)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  // Monitor: everything the DUT emits, sampled mid-cycle.
  int got_q[$];
  int vcyc_q[$];
  int err_cnt = 0, both_cnt = 0, err_cyc = 0;
  always @(negedge clkin) begin
    if (valid) begin
      got_q.push_back(int'({ch_out, data_out}));
      vcyc_q.push_back(cyc);
    end
    if (frame_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (valid && frame_err) both_cnt = both_cnt + 1;
  end

  int n_asserts = 0, n_fail = 0;
  int exp_q[$];
  int edge_q[$];
  int got_rd = 0, exp_rd = 0, err_base = 0;
  int last_edge_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic f, input int half);
    @(negedge clkin);
    sclk_in = 1'b0; sd_in = b; fs_in = f;
    repeat (half - 1) @(negedge clkin);
    @(negedge clkin);
    sclk_in = 1'b1;
    last_edge_cyc = cyc;
    repeat (half - 1) @(negedge clkin);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic fs_first,
                           input int half, input int nbits);
    for (int i = 0; i < nbits; i++)
      send_bit(w[W-1-i], fs_first && (i == 0), half);
    if (nbits == W) edge_q.push_back(last_edge_cyc);
  endtask

  // Reference: a complete frame yields word k on channel k, in order.
  task automatic send_frame(input logic [W-1:0] w [N], input int half);
    for (int k = 0; k < N; k++) begin
      send_word(w[k], k == 0, half, W);
      exp_q.push_back(k * 4096 + int'(w[k]));
    end
  endtask

  task automatic idle(input int n);
    @(negedge clkin);
    sclk_in = 1'b0; fs_in = 1'b0;
    repeat (n) @(negedge clkin);
  endtask

  task automatic rand_frame(output logic [W-1:0] w [N]);
    for (int k = 0; k < N; k++) w[k] = W'($urandom_range(0, 4095));
  endtask

  task automatic check_results(input string name, input int n_err);
    int n_exp, n_got;
    idle(12);
    n_exp = exp_q.size() - exp_rd;
    n_got = got_q.size() - got_rd;
    check({name, " valid count"}, n_got, n_exp);
    for (int i = 0; i < n_exp; i++)
      if (got_rd + i < got_q.size())
        check($sformatf("%s word %0d {ch,data}", name, i), got_q[got_rd + i], exp_q[exp_rd + i]);
    check({name, " frame_err count"}, err_cnt - err_base, n_err);
    check({name, " valid with frame_err"}, both_cnt, 0);
    check({name, " busy idle"}, busy, 1'b0);
    got_rd = got_q.size();
    exp_rd = exp_q.size();
    err_base = err_cnt;
  endtask

  logic [W-1:0] fa [N];
  logic [W-1:0] fb [N];
  int e0, v0;

  initial begin
    rst = 1'b1; sclk_in = 1'b0; fs_in = 1'b0; sd_in = 1'b0;
    repeat (4) @(negedge clkin);
    check("reset data_out", data_out, 0);
    check("reset ch_out", ch_out, 0);
    check("reset valid", valid, 0);
    check("reset busy", busy, 0);
    check("reset frame_err", frame_err, 0);
    rst = 1'b0;
    idle(4);

    // Nominal frame at clkin/16.
    fa[0] = 12'hBA2; fa[1] = 12'h123; fa[2] = 12'hFFF; fa[3] = 12'h000;
    send_word(fa[0], 1'b1, 8, 6);
    check("nominal busy mid-word", busy, 1'b1);
    send_word(fa[0] << 6, 1'b0, 8, 6);
    exp_q.push_back(int'(fa[0]));
    for (int k = 1; k < N; k++) begin
      send_word(fa[k], 1'b0, 8, W);
      exp_q.push_back(k * 4096 + int'(fa[k]));
    end
    check_results("nominal", 0);

    // Back-to-back frames, no idle bits in between.
    rand_frame(fa); rand_frame(fb);
    send_frame(fa, 8);
    send_frame(fb, 8);
    check_results("back2back", 0);

    // fs re-asserted after 5 bits of word 1.
    rand_frame(fa); rand_frame(fb);
    send_word(fa[0], 1'b1, 8, W);
    exp_q.push_back(int'(fa[0]));
    send_word(fa[1], 1'b0, 8, 5);
    send_frame(fb, 8);
    check_results("fs_restart", 1);

    // sclk stalls after 7 bits of word 2.
    rand_frame(fa);
    for (int k = 0; k < 2; k++) begin
      send_word(fa[k], k == 0, 8, W);
      exp_q.push_back(k * 4096 + int'(fa[k]));
    end
    send_word(fa[2], 1'b0, 8, 7);
    idle(80);
    check("timeout busy", busy, 1'b0);
    check("timeout err delay window", (err_cyc - last_edge_cyc >= 64) && (err_cyc - last_edge_cyc <= 72), 1'b1);
    rand_frame(fb);
    send_frame(fb, 8);
    check_results("timeout", 1);

    // Synchronous reset pulse mid-word 1.
    rand_frame(fa);
    fa[0] = fa[0] | 12'h001;
    send_word(fa[0], 1'b1, 8, W);
    exp_q.push_back(int'(fa[0]));
    send_word(fa[1], 1'b0, 8, 6);
    idle(4);
    rst = 1'b1;
    @(negedge clkin);
    rst = 1'b0;
    check("rst data_out", data_out, 0);
    check("rst ch_out", ch_out, 0);
    check("rst busy", busy, 0);
    rand_frame(fb);
    send_frame(fb, 8);
    check_results("mid_reset", 0);

    // Minimum rate clkin/4 with alternating patterns, plus latency.
    e0 = edge_q.size();
    v0 = vcyc_q.size();
    fa[0] = 12'h555; fa[1] = 12'hAAA; fa[2] = 12'h555; fa[3] = 12'hAAA;
    rand_frame(fb);
    send_frame(fa, 2);
    send_frame(fb, 2);
    check_results("min_rate", 0);
    for (int i = 0; i < 2 * N; i++)
      if (v0 + i < vcyc_q.size() && e0 + i < edge_q.size())
        check($sformatf("min_rate latency %0d", i), vcyc_q[v0 + i] - edge_q[e0 + i], 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/serial2parallel.md
Name: serial2parallel

Overview:
- Receive-side deserializer for the CPLD sample path; the opposite end of the parallel-to-serial link that carries AD7864 conversion results.
- Oversamples an external serial clock, frame sync and data line on the fast system clock.
- Rebuilds each frame of NCH words of WIDTH bits into parallel words tagged with a channel index.
- Used on the loopback or verification side of the link, and for DSP-to-CPLD command frames.

Parameters:
- WIDTH, 12, bits per word, MSB first.
- NCH, 4, words per frame; channel index is 0..NCH-1.
- TIMEOUT, 64, clkin cycles without an sclk rising edge mid-frame before the frame is aborted.

Ports:
- clkin  in  1  system clock, at least 4x the sclk_in frequency.
- rst  in  1  synchronous, active-high reset.
- sclk_in  in  1  serial bit clock, asynchronous to clkin.
- fs_in  in  1  frame sync, active high, asynchronous.
- sd_in  in  1  serial data, asynchronous; valid on sclk_in rising edge.
- data_out  out  WIDTH  last completed word.
- ch_out  out  2  channel index of data_out (width is clog2(NCH)).
- valid  out  1  one-cycle strobe when data_out/ch_out update.
- busy  out  1  high while a frame is in progress.
- frame_err  out  1  one-cycle strobe when a frame is aborted.

Behaviour:
- Clock and reset: one clock (clkin); reset is synchronous and active-high.
- Synchronizers:
  - sclk_in, fs_in and sd_in each pass through a 2-flop synchronizer, plus one extra stage on sclk for edge detection.
  - sclk_rise is asserted for one clkin cycle when the synchronized sclk goes 0 to 1.
  - fs and sd are sampled only on sclk_rise cycles, using their synchronized values.
- Reset:
  - data_out=0, ch_out=0, valid=0, busy=0, frame_err=0.
  - FSM to IDLE; bit and word counters to 0; timeout counter to 0; synchronizer flops to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On sclk_rise with fs=1, go to SHIFT and clear bit_cnt, word_cnt and the shift register.
  - That same sclk edge carries the MSB of word 0; shift sd in.
- SHIFT:
  - On each sclk_rise, shift_reg <= {shift_reg[WIDTH-2:0], sd} and increment bit_cnt.
  - When the WIDTH-th bit is shifted in, on the next clkin cycle:
    - data_out <= assembled word, ch_out <= word_cnt, valid=1 for exactly one cycle;
    - bit_cnt is cleared.
  - Latency: valid rises 1 clkin cycle after the sclk_rise cycle of the last bit, which is 4 clkin cycles after the raw sclk_in edge.
  - When word NCH-1 completes, go to DONE. Otherwise increment word_cnt, wrapping is not allowed.
- DONE: one clkin cycle, busy deasserts, then IDLE. A new frame may begin on the next sclk_rise.
- busy: 1 in SHIFT and DONE, 0 in IDLE.
- fs seen again mid-frame (sclk_rise with fs=1 while in SHIFT and bit_cnt != 0, or word_cnt != 0 with bit_cnt=0):
  - frame_err pulses for 1 cycle;
  - the partial word is discarded with no valid;
  - a new frame restarts immediately, with that bit taken as the MSB of word 0.
- Timeout:
  - In SHIFT, the counter increments each clkin cycle without sclk_rise and clears on sclk_rise.
  - Reaching TIMEOUT gives a frame_err pulse, the partial word is discarded, and the FSM returns to IDLE.
- fs held high across words is ignored after the first edge. Only a fs=1 sample with the FSM not at a word boundary, or after completion, counts.
- valid and frame_err are never high in the same cycle. If both occur, frame_err wins and the word is dropped.
- rst asserted mid-frame: all state clears on the next clkin edge and no valid is emitted.

Decomposition:
- Shared package s2p_pkg holds:
  - state encoding (IDLE, SHIFT, DONE);
  - defaults WIDTH=12, NCH=4, TIMEOUT=64;
  - the channel index width function.
- One sub-module, sync_edge: 2-flop synchronizer plus rising-edge detector, instantiated for sclk. Plain 2-flop instances use the same module with the edge output unused.

Test Plan:
- Nominal frame, sclk = clkin/16: fs=1 on the first bit; send words 0xBA2, 0x123, 0xFFF, 0x000. Expect 4 valid pulses, ch 0..3, data exact, busy low after DONE, frame_err never.
- Back-to-back frames with no idle bits: the second frame's fs comes on the sclk edge after word 3 completes. Expect 8 valids, no error.
- fs reasserted after 5 bits of word 1: expect frame_err pulse, no valid for word 1, the new frame decoded correctly from ch 0.
- sclk stops after 7 bits of word 2 for 70 clkin cycles: frame_err at cycle 64 of inactivity, busy=0, next frame decodes normally.
- rst pulsed for 1 cycle mid-word 1: outputs return to reset values, no valid; the following frame gives ch 0..3 correctly.
- Minimum-rate check, sclk = clkin/4 with 0x555/0xAAA patterns: all words exact; valid 4 clkin cycles after the last raw sclk edge.
